// File: rtl/button_conditioner_if.sv
// Signal bundle for the button conditioner: raw active-low buttons and repeat
// enables toward the conditioner, pulses and debounced levels back out.
interface button_conditioner_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] Btt_in;
    logic [N_BTN-1:0] rpt_en;
    logic [N_BTN-1:0] Btt_out;
    logic [N_BTN-1:0] Btt_held;
    logic             any_pulse;

    modport master (
        output Btt_in,
        output rpt_en,
        input  Btt_out,
        input  Btt_held,
        input  any_pulse
    );

    modport slave (
        input  Btt_in,
        input  rpt_en,
        output Btt_out,
        output Btt_held,
        output any_pulse
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-channel button conditioner: synchronize, debounce, then emit a press
// pulse followed by optional auto-repeat pulses while the button stays held.
module button_conditioner #(
    parameter int N_BTN      = 4,
    parameter int DEB_CYCLES = 500000,
    parameter int RPT_DELAY  = 25000000,
    parameter int RPT_PERIOD = 5000000,
    parameter int CNT_W      = 25
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  bus
);
    // state     | meaning
    // ST_IDLE   | debounced level released, no pulses
    // ST_HELD   | pressed, counting toward the first repeat
    // ST_REPEAT | pressed, repeating every RPT_PERIOD cycles
    typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_REPEAT} state_t;

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(RPT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(RPT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [N_BTN-1:0] out_v;
    logic [N_BTN-1:0] held_v;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        logic             sync1_q;
        logic             sync2_q;
        logic             held_q;
        logic             out_q;
        logic [CNT_W-1:0] deb_cnt_q;
        logic [CNT_W-1:0] rpt_cnt_q;
        state_t           state_q;
        logic             deb_flip;
        logic             rpt_hit;

        // The FSM reacts on the same edge the debounced level flips, so the
        // press pulse and the held level rise together.
        assign deb_flip = (sync2_q != held_q) && (deb_cnt_q == DEB_LAST);
        assign rpt_hit  = rpt_cnt_q == ((state_q == ST_HELD) ? DELAY_LAST : PERIOD_LAST);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                held_q    <= 1'b0;
                out_q     <= 1'b0;
                deb_cnt_q <= '0;
                rpt_cnt_q <= '0;
                state_q   <= ST_IDLE;
            end else begin
                sync1_q <= ~bus.Btt_in[i];
                sync2_q <= sync1_q;
                out_q   <= 1'b0;

                if (sync2_q == held_q) begin
                    deb_cnt_q <= '0;
                end else if (deb_flip) begin
                    deb_cnt_q <= '0;
                    held_q    <= ~held_q;
                end else begin
                    deb_cnt_q <= deb_cnt_q + CNT_ONE;
                end

                case (state_q)
                    ST_IDLE: begin
                        if (deb_flip) begin
                            state_q   <= ST_HELD;
                            out_q     <= 1'b1;
                            rpt_cnt_q <= '0;
                        end
                    end
                    ST_HELD, ST_REPEAT: begin
                        // Release takes priority over a repeat due on the same edge.
                        if (deb_flip) begin
                            state_q   <= ST_IDLE;
                            rpt_cnt_q <= '0;
                        end else if (!bus.rpt_en[i]) begin
                            rpt_cnt_q <= '0;
                        end else if (rpt_hit) begin
                            out_q     <= 1'b1;
                            rpt_cnt_q <= '0;
                            state_q   <= ST_REPEAT;
                        end else begin
                            rpt_cnt_q <= rpt_cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        rpt_cnt_q <= '0;
                    end
                endcase
            end
        end

        assign out_v[i]  = out_q;
        assign held_v[i] = held_q;
    end

    assign bus.Btt_out   = out_v;
    assign bus.Btt_held  = held_v;
    assign bus.any_pulse = |out_v;
endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random
// stimulus compared against a window/deadline reference model.
module tb_button_conditioner;
    localparam int N   = 2;
    localparam int DEB = 4;
    localparam int DLY = 10;
    localparam int PER = 3;
    localparam int CW  = 5;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    button_conditioner_if #(.N_BTN(N)) bus ();

    button_conditioner #(
        .N_BTN      (N),
        .DEB_CYCLES (DEB),
        .RPT_DELAY  (DLY),
        .RPT_PERIOD (PER),
        .CNT_W      (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a level is accepted once the last DEB synchronized
    // samples all disagree with it; repeats follow an absolute deadline.
    bit             smp_q [N][$];
    bit             m_held [N];
    bit             m_rep [N];
    int             m_deadline [N];
    int             m_edge;
    logic [N-1:0]   exp_out;
    logic [N-1:0]   exp_held;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_edge   = 0;
            exp_out  = '0;
            exp_held = '0;
            for (int ch = 0; ch < N; ch++) begin
                smp_q[ch].delete();
                for (int k = 0; k < DEB + 2; k++) smp_q[ch].push_back(1'b0);
                m_held[ch]     = 1'b0;
                m_rep[ch]      = 1'b0;
                m_deadline[ch] = 0;
            end
        end else begin
            m_edge++;
            for (int ch = 0; ch < N; ch++) begin
                bit accept;
                smp_q[ch].push_back(!bus.Btt_in[ch]);
                void'(smp_q[ch].pop_front());
                exp_out[ch] = 1'b0;
                accept = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (smp_q[ch][DEB - 1 - j] == m_held[ch]) accept = 1'b0;
                if (accept) begin
                    m_held[ch] = !m_held[ch];
                    if (m_held[ch]) begin
                        exp_out[ch]    = 1'b1;
                        m_rep[ch]      = 1'b0;
                        m_deadline[ch] = m_edge + DLY;
                    end
                end else if (m_held[ch]) begin
                    if (!bus.rpt_en[ch]) begin
                        m_deadline[ch] = m_edge + (m_rep[ch] ? PER : DLY);
                    end else if (m_edge == m_deadline[ch]) begin
                        exp_out[ch]    = 1'b1;
                        m_rep[ch]      = 1'b1;
                        m_deadline[ch] = m_edge + PER;
                    end
                end
                exp_held[ch] = m_held[ch];
            end
        end
    end

    // Puts the DUT in reset and releases it so the next rising edge is edge 1.
    task automatic start_run(input logic [N-1:0] btn, input logic [N-1:0] en);
        @(posedge clk); #1;
        reset = 1'b1;
        bus.Btt_in = '1;
        bus.rpt_en = '0;
        @(posedge clk);
        @(posedge clk); #1;
        bus.Btt_in = btn;
        bus.rpt_en = en;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.Btt_in = '0;
        bus.rpt_en = '1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.Btt_out !== '0) begin
            n_errors++;
            $display("FAIL reset_out got %b expected 00", bus.Btt_out);
        end
        n_checks++;
        if (bus.Btt_held !== '0) begin
            n_errors++;
            $display("FAIL reset_held got %b expected 00", bus.Btt_held);
        end
        n_checks++;
        if (bus.any_pulse !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_any got %b expected 0", bus.any_pulse);
        end
    endtask

    task automatic test_press_release();
        start_run(2'b10, 2'b00);
        for (int e = 1; e <= 30; e++) begin
            logic [N-1:0] d_out;
            logic [N-1:0] d_held;
            @(posedge clk); #1;
            d_out  = {1'b0, (e == 6)};
            d_held = {1'b0, (e >= 6 && e < 20)};
            n_checks++;
            if (bus.Btt_out !== d_out || bus.Btt_out !== exp_out) begin
                n_errors++;
                $display("FAIL press_out edge %0d got %b expected %b model %b", e, bus.Btt_out, d_out, exp_out);
            end
            n_checks++;
            if (bus.Btt_held !== d_held || bus.Btt_held !== exp_held) begin
                n_errors++;
                $display("FAIL press_held edge %0d got %b expected %b model %b", e, bus.Btt_held, d_held, exp_held);
            end
            if (e == 14) bus.Btt_in = 2'b11;
        end
    endtask

    task automatic test_glitch();
        start_run(2'b11, 2'b00);
        for (int e = 1; e <= 40; e++) begin
            logic [N-1:0] d_out;
            logic [N-1:0] d_held;
            @(posedge clk); #1;
            d_out  = {1'b0, (e == 31)};
            d_held = {1'b0, (e >= 31 && e < 35)};
            n_checks++;
            if (bus.Btt_out !== d_out || bus.Btt_out !== exp_out) begin
                n_errors++;
                $display("FAIL glitch_out edge %0d got %b expected %b model %b", e, bus.Btt_out, d_out, exp_out);
            end
            n_checks++;
            if (bus.Btt_held !== d_held || bus.Btt_held !== exp_held) begin
                n_errors++;
                $display("FAIL glitch_held edge %0d got %b expected %b model %b", e, bus.Btt_held, d_held, exp_held);
            end
            if (e == 2 || e == 25) bus.Btt_in[0] = 1'b0;
            if (e == 5 || e == 29) bus.Btt_in[0] = 1'b1;
        end
    endtask

    task automatic test_repeat();
        for (int r = 0; r < 2; r++) begin
            start_run(2'b01, 2'b10);
            for (int e = 1; e <= ((r == 0) ? 25 : 40); e++) begin
                logic p;
                @(posedge clk); #1;
                if (r == 0) p = (e == 6) || (e >= 16 && (e - 16) % 3 == 0);
                else        p = (e == 6) || (e == 16) || (e >= 28 && (e - 28) % 3 == 0);
                n_checks++;
                if (bus.Btt_out !== {p, 1'b0} || bus.Btt_out !== exp_out) begin
                    n_errors++;
                    $display("FAIL repeat_out run %0d edge %0d got %b expected %b model %b", r, e, bus.Btt_out, {p, 1'b0}, exp_out);
                end
                n_checks++;
                if (bus.any_pulse !== p) begin
                    n_errors++;
                    $display("FAIL repeat_any run %0d edge %0d got %b expected %b", r, e, bus.any_pulse, p);
                end
                if (r == 1 && e == 18) bus.rpt_en = 2'b00;
                if (r == 1 && e == 25) bus.rpt_en = 2'b10;
            end
        end
    endtask

    task automatic test_simultaneous();
        start_run(2'b00, 2'b00);
        for (int e = 1; e <= 10; e++) begin
            logic [N-1:0] d_out;
            @(posedge clk); #1;
            d_out = (e == 6) ? 2'b11 : 2'b00;
            n_checks++;
            if (bus.Btt_out !== d_out || bus.Btt_out !== exp_out) begin
                n_errors++;
                $display("FAIL simul_out edge %0d got %b expected %b model %b", e, bus.Btt_out, d_out, exp_out);
            end
            n_checks++;
            if (bus.any_pulse !== (e == 6)) begin
                n_errors++;
                $display("FAIL simul_any edge %0d got %b expected %b", e, bus.any_pulse, (e == 6));
            end
        end
    endtask

    task automatic test_reset_mid_repeat();
        start_run(2'b01, 2'b10);
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.Btt_out !== exp_out || bus.Btt_held !== exp_held) begin
                n_errors++;
                $display("FAIL midrst_pre edge %0d got out %b held %b model out %b held %b", e, bus.Btt_out, bus.Btt_held, exp_out, exp_held);
            end
        end
        n_checks++;
        if (bus.Btt_out !== 2'b10) begin
            n_errors++;
            $display("FAIL midrst_pulse16 got %b expected 10", bus.Btt_out);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.Btt_out !== 2'b00 || bus.Btt_held !== 2'b00 || bus.any_pulse !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_async got out %b held %b any %b expected 00 00 0", bus.Btt_out, bus.Btt_held, bus.any_pulse);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            logic [N-1:0] d_out;
            @(posedge clk); #1;
            d_out = {(e == 6), 1'b0};
            n_checks++;
            if (bus.Btt_out !== d_out || bus.Btt_out !== exp_out) begin
                n_errors++;
                $display("FAIL midrst_post edge %0d got %b expected %b model %b", e, bus.Btt_out, d_out, exp_out);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] prev_out;
        start_run('1, '1);
        prev_out = '0;
        for (int e = 1; e <= 600; e++) begin
            int rate;
            @(posedge clk); #1;
            n_checks++;
            if (bus.Btt_out !== exp_out) begin
                n_errors++;
                $display("FAIL rand_out edge %0d got %b model %b", e, bus.Btt_out, exp_out);
            end
            n_checks++;
            if (bus.Btt_held !== exp_held) begin
                n_errors++;
                $display("FAIL rand_held edge %0d got %b model %b", e, bus.Btt_held, exp_held);
            end
            n_checks++;
            if (bus.any_pulse !== (|exp_out)) begin
                n_errors++;
                $display("FAIL rand_any edge %0d got %b model %b", e, bus.any_pulse, (|exp_out));
            end
            n_checks++;
            if ((prev_out & bus.Btt_out) !== '0) begin
                n_errors++;
                $display("FAIL rand_consec edge %0d got %b after %b expected no overlap", e, bus.Btt_out, prev_out);
            end
            prev_out = bus.Btt_out;
            rate = ((e / 100) % 2 == 0) ? 4 : 30;
            for (int ch = 0; ch < N; ch++) begin
                if ($urandom_range(rate - 1, 0) == 0) bus.Btt_in[ch] = ~bus.Btt_in[ch];
                if ($urandom_range(39, 0) == 0) bus.rpt_en[ch] = ~bus.rpt_en[ch];
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        bus.Btt_in = '1;
        bus.rpt_en = '0;
        test_reset();
        test_press_release();
        test_glitch();
        test_repeat();
        test_simultaneous();
        test_reset_mid_repeat();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
